change_dispenser: RTL and testbench
===================================

# change_dispenser

Change-return engine on the output side of the vending controller. It accepts a change amount in Rs. 5 units from the controller's `change` path, pays it out greedily as Rs. 10 and Rs. 5 coins by pulsing two hopper solenoids, and tracks hopper inventory. It reports completion, and any shortfall when the hoppers cannot make exact change.

## Interface
Parameters:
- `AMT_W`, 4, width of amount fields in Rs. 5 units (max 15 = Rs. 75)
- `CNT_W`, 6, width of each hopper inventory counter
- `PULSE_CYC`, 4, cycles each eject solenoid is held high (≥1)
- `GAP_CYC`, 2, idle cycles after each eject pulse (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `req_valid` in 1: change request valid
- `req_amt` in AMT_W: change to pay, Rs. 5 units
- `req_ready` out 1: high only in IDLE
- `load_en` in 1: inventory load strobe; honoured only in IDLE
- `load_ten` in CNT_W: new Rs. 10 coin count
- `load_five` in CNT_W: new Rs. 5 coin count
- `eject10` out 1: Rs. 10 hopper solenoid
- `eject5` out 1: Rs. 5 hopper solenoid
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle completion pulse
- `short` out 1: valid with `done`; exact change not paid
- `rem_amt` out AMT_W: valid with `done`; unpaid remainder (0 when `short`=0)
- `cnt_ten`, `cnt_five` out CNT_W: current inventory

## Operation
- States: IDLE, SELECT, EJECT, GAP, DONE. All outputs are registered or decoded from the state register.
- IDLE: `req_ready`=1.
  - `load_en` writes both counters.
  - On `req_valid & req_ready`, latch `rem` ← `req_amt`.
  - If `req_amt`==0, go to DONE; otherwise go to SELECT.
  - A load and an accept on the same edge are both honoured. SELECT sees the loaded counts.
- SELECT (1 cycle), greedy choice in priority order:
  - `rem`≥2 and `cnt_ten`>0: choose 10.
  - Else `rem`≥1 and `cnt_five`>0: choose 5.
  - Else go to DONE.
  - The block never overpays. With `rem`==1 and no fives, it stops short even if tens remain.
- EJECT: assert `eject10` or `eject5` for exactly PULSE_CYC cycles.
  - The two ejects are never high together.
  - On exit, decrement the chosen counter by 1 and `rem` by 2 (ten) or 1 (five). Go to GAP.
- GAP: GAP_CYC cycles with both ejects low, then SELECT.
- DONE (1 cycle): `done`=1, `short`=(`rem`≠0), `rem_amt`=`rem`. Then IDLE.
- `load_en` outside IDLE is ignored. `req_valid` outside IDLE is not accepted; the requester holds it.
- Counters cannot underflow: an eject is issued only when the count is >0.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, `req_ready`=1.
  - `busy`=`done`=`short`=`eject10`=`eject5`=0.
  - `rem_amt`=0, `cnt_ten`=`cnt_five`=0.
- Reset mid-operation: ejects drop immediately and the request is discarded. Inventory returns to 0 and must be reloaded.
- Acceptance edge = cycle 0. SELECT occupies cycle 1.
- For n coins paid, `done` is high in cycle n·(1+PULSE_CYC+GAP_CYC)+2.
  - Defaults: 7n+2.
  - Zero request: `done` in cycle 1.
- The first eject goes high in cycle 2.
- `req_ready` returns in the cycle after `done`. A new request can be accepted at the end of that cycle.
- `busy` = !`req_ready`.

## Test plan
- Load ten=3, five=3; req 4 (Rs. 20).
  - Two `eject10` pulses of 4 cycles, 2-cycle gap.
  - `done` in cycle 16, `short`=0, `cnt_ten`=1, `cnt_five`=3.
- Load ten=0, five=5; req 3.
  - Three `eject5` pulses.
  - `done` in cycle 23, `cnt_five`=2, `short`=0.
- Load ten=2, five=0; req 3.
  - One `eject10`.
  - `done` in cycle 9 with `short`=1, `rem_amt`=1, `cnt_ten`=1.
- Req 0.
  - `done` in cycle 1, no eject, `short`=0.
  - Load with simultaneous accept: SELECT uses the new counts.
- Assert `rst_n` low during `eject10`.
  - `eject10` falls within the same cycle; counters go to 0; `req_ready`=1 after release.
- `load_en` pulsed while busy: counts unchanged.
- `req_valid` held through a transaction: the second request is accepted only in the cycle after `done`.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Bundle of the change-request, inventory-load and hopper/status signals
// between the vending controller (master) and the change dispenser (slave).
//   req_valid/req_amt/req_ready : change request handshake, Rs. 5 units
//   load_en/load_ten/load_five  : hopper inventory load
//   eject10/eject5              : hopper solenoid drives
//   busy/done/short/rem_amt     : status and completion report
//   cnt_ten/cnt_five            : current hopper inventory
interface change_dispenser_if #(
  parameter int unsigned AMT_W = 4,
  parameter int unsigned CNT_W = 6
);

  logic             req_valid;
  logic [AMT_W-1:0] req_amt;
  logic             req_ready;
  logic             load_en;
  logic [CNT_W-1:0] load_ten;
  logic [CNT_W-1:0] load_five;
  logic             eject10;
  logic             eject5;
  logic             busy;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] rem_amt;
  logic [CNT_W-1:0] cnt_ten;
  logic [CNT_W-1:0] cnt_five;

  modport master (
    output req_valid, req_amt, load_en, load_ten, load_five,
    input  req_ready, eject10, eject5, busy, done, short, rem_amt,
           cnt_ten, cnt_five
  );

  modport slave (
    input  req_valid, req_amt, load_en, load_ten, load_five,
    output req_ready, eject10, eject5, busy, done, short, rem_amt,
           cnt_ten, cnt_five
  );

endinterface

// File: rtl/change_dispenser.sv
// Change-return engine: pays a requested amount (Rs. 5 units) greedily as
// Rs. 10 then Rs. 5 coins by pulsing two hopper solenoids, tracks hopper
// inventory and reports completion plus any unpaid remainder.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : change_dispenser_if.slave (request, load, ejects, status)
module change_dispenser #(
  parameter int unsigned AMT_W     = 4,
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  change_dispenser_if.slave    bus
);

  localparam int unsigned TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    EJECT  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state, state_nxt;

  logic [AMT_W-1:0] rem, rem_nxt;
  logic             sel_ten, sel_ten_nxt;
  logic [TMR_W-1:0] tmr, tmr_nxt;
  logic [CNT_W-1:0] cnt_ten, cnt_ten_nxt;
  logic [CNT_W-1:0] cnt_five, cnt_five_nxt;

  logic             done_q, done_nxt;
  logic             short_q, short_nxt;
  logic [AMT_W-1:0] rem_amt_q, rem_amt_nxt;
  logic             eject10_q, eject10_nxt;
  logic             eject5_q, eject5_nxt;
  logic             ready_q, ready_nxt;
  logic             busy_q, busy_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem       <= '0;
      sel_ten   <= 1'b0;
      tmr       <= '0;
      cnt_ten   <= '0;
      cnt_five  <= '0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      rem_amt_q <= '0;
      eject10_q <= 1'b0;
      eject5_q  <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      rem       <= rem_nxt;
      sel_ten   <= sel_ten_nxt;
      tmr       <= tmr_nxt;
      cnt_ten   <= cnt_ten_nxt;
      cnt_five  <= cnt_five_nxt;
      done_q    <= done_nxt;
      short_q   <= short_nxt;
      rem_amt_q <= rem_amt_nxt;
      eject10_q <= eject10_nxt;
      eject5_q  <= eject5_nxt;
      ready_q   <= ready_nxt;
      busy_q    <= busy_nxt;
    end
  end

  // Next-state, datapath update and next-output decode
  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    sel_ten_nxt  = sel_ten;
    tmr_nxt      = tmr;
    cnt_ten_nxt  = cnt_ten;
    cnt_five_nxt = cnt_five;
    rem_amt_nxt  = rem_amt_q;
    done_nxt     = 1'b0;
    short_nxt    = 1'b0;

    case (state)
      IDLE: begin
        // Load and accept may coincide; SELECT then sees the loaded counts.
        if (bus.load_en) begin
          cnt_ten_nxt  = bus.load_ten;
          cnt_five_nxt = bus.load_five;
        end
        if (bus.req_valid) begin
          rem_nxt   = bus.req_amt;
          state_nxt = (bus.req_amt == '0) ? DONE : SELECT;
        end
      end

      SELECT: begin
        // Greedy, never overpaying: a lone Rs. 5 remainder cannot use a ten.
        if ((rem >= AMT_W'(2)) && (cnt_ten != '0)) begin
          sel_ten_nxt = 1'b1;
          tmr_nxt     = PULSE_LD;
          state_nxt   = EJECT;
        end else if ((rem != '0) && (cnt_five != '0)) begin
          sel_ten_nxt = 1'b0;
          tmr_nxt     = PULSE_LD;
          state_nxt   = EJECT;
        end else begin
          state_nxt = DONE;
        end
      end

      EJECT: begin
        if (tmr == '0) begin
          // Coin is out: book it against inventory and the remainder.
          if (sel_ten) begin
            cnt_ten_nxt = cnt_ten - CNT_W'(1);
            rem_nxt     = rem - AMT_W'(2);
          end else begin
            cnt_five_nxt = cnt_five - CNT_W'(1);
            rem_nxt      = rem - AMT_W'(1);
          end
          tmr_nxt   = GAP_LD;
          state_nxt = GAP;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end

      GAP: begin
        if (tmr == '0) begin
          state_nxt = SELECT;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Completion report is captured on entry to DONE so it lines up with done.
    if (state_nxt == DONE) begin
      done_nxt    = 1'b1;
      short_nxt   = (rem_nxt != '0);
      rem_amt_nxt = rem_nxt;
    end
  end

  // Output decode from the next state so the registered outputs track state
  always_comb begin
    eject10_nxt = (state_nxt == EJECT) &&  sel_ten_nxt;
    eject5_nxt  = (state_nxt == EJECT) && !sel_ten_nxt;
    ready_nxt   = (state_nxt == IDLE);
    busy_nxt    = (state_nxt != IDLE);
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.eject10   = eject10_q;
  assign bus.eject5    = eject5_q;
  assign bus.done      = done_q;
  assign bus.short     = short_q;
  assign bus.rem_amt   = rem_amt_q;
  assign bus.cnt_ten   = cnt_ten;
  assign bus.cnt_five  = cnt_five;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed cases plus randomized
// transactions compared against a greedy coin-count model.
module tb_change_dispenser;

  localparam int unsigned AMT_W     = 4;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned PULSE_CYC = 4;
  localparam int unsigned GAP_CYC   = 2;
  localparam int          COIN_CYC  = 1 + PULSE_CYC + GAP_CYC;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  change_dispenser_if #(.AMT_W(AMT_W), .CNT_W(CNT_W)) bus ();

  change_dispenser #(
    .AMT_W(AMT_W), .CNT_W(CNT_W), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int m_ten    = 0;
  int m_five   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Greedy payout: as many tens as fit (never overpaying), then fives.
  function automatic void greedy(input int amt, input int ten, input int five,
                                 output int n10, output int n5, output int left);
    n10  = (amt / 2 < ten) ? amt / 2 : ten;
    left = amt - 2 * n10;
    n5   = (left < five) ? left : five;
    left = left - n5;
  endfunction

  function automatic int done_cycle(input int amt, input int coins);
    return (amt == 0) ? 1 : coins * COIN_CYC + 2;
  endfunction

  task automatic wait_ready();
    int k = 0;
    while (bus.req_ready !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 32'(bus.req_ready), 1);
  endtask

  // One request; cycle 1 is the first negedge after the accepting edge.
  task automatic run_txn(input bit do_load, input int ten, input int five, input int amt,
                         input bit busy_load, input bit hold);
    int n10, n5, left, coins, cyc, done_cyc, first_ej, h10, h5, p10, p5, k;
    logic pe10, pe5, sh;
    logic [31:0] ra, ct, cf;
    bit both, bad_busy;
    wait_ready();
    @(negedge clk);
    bus.load_en   = do_load;
    bus.load_ten  = CNT_W'(ten);
    bus.load_five = CNT_W'(five);
    bus.req_valid = 1'b1;
    bus.req_amt   = AMT_W'(amt);
    if (do_load) begin
      m_ten  = ten;
      m_five = five;
    end
    greedy(amt, m_ten, m_five, n10, n5, left);
    coins = n10 + n5;
    @(negedge clk);
    bus.load_en = 1'b0;
    if (!hold) bus.req_valid = 1'b0;
    cyc = 1; done_cyc = -1; first_ej = -1;
    h10 = 0; h5 = 0; p10 = 0; p5 = 0; pe10 = 1'b0; pe5 = 1'b0;
    both = 1'b0; bad_busy = 1'b0; sh = 1'bx; ra = 'x; ct = 'x; cf = 'x;
    while (cyc < 300) begin
      if (bus.eject10 && bus.eject5) both = 1'b1;
      if (bus.busy === bus.req_ready) bad_busy = 1'b1;
      if (bus.eject10) h10++;
      if (bus.eject5) h5++;
      if (bus.eject10 && !pe10) p10++;
      if (bus.eject5 && !pe5) p5++;
      if ((bus.eject10 || bus.eject5) && first_ej < 0) first_ej = cyc;
      pe10 = bus.eject10;
      pe5  = bus.eject5;
      if (bus.done === 1'b1) begin
        done_cyc = cyc;
        sh = bus.short; ra = 32'(bus.rem_amt);
        ct = 32'(bus.cnt_ten); cf = 32'(bus.cnt_five);
        break;
      end
      if (busy_load && cyc == 3) begin
        bus.load_en   = 1'b1;
        bus.load_ten  = CNT_W'(63);
        bus.load_five = CNT_W'(63);
      end else begin
        bus.load_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.load_en = 1'b0;
    m_ten  -= n10;
    m_five -= n5;
    chk("done_cycle", done_cyc, done_cycle(amt, coins));
    chk("short", 32'(sh), 32'(left != 0));
    chk("rem_amt", ra, left);
    chk("cnt_ten", ct, m_ten);
    chk("cnt_five", cf, m_five);
    chk("pulses10", p10, n10);
    chk("pulses5", p5, n5);
    chk("high10", h10, n10 * PULSE_CYC);
    chk("high5", h5, n5 * PULSE_CYC);
    chk("first_eject", first_ej, (coins > 0) ? 2 : -1);
    chk("both_ejects", 32'(both), 0);
    chk("busy_vs_ready", 32'(bad_busy), 0);
    @(negedge clk);
    chk("ready_after_done", 32'(bus.req_ready), 1);
    if (hold) begin
      // The held request is taken at the end of the ready cycle, not earlier.
      @(negedge clk);
      chk("hold_accept", 32'(bus.busy), 1);
      bus.req_valid = 1'b0;
      greedy(amt, m_ten, m_five, n10, n5, left);
      coins = n10 + n5;
      k = 1;
      while (bus.done !== 1'b1 && k < 300) begin
        @(negedge clk);
        k++;
      end
      m_ten  -= n10;
      m_five -= n5;
      chk("hold_done_cycle", k, done_cycle(amt, coins));
      chk("hold_short", 32'(bus.short), 32'(left != 0));
      chk("hold_cnt_ten", 32'(bus.cnt_ten), m_ten);
      chk("hold_cnt_five", 32'(bus.cnt_five), m_five);
      @(negedge clk);
    end
  endtask

  initial begin
    int k;
    bus.req_valid = 1'b0;
    bus.req_amt   = '0;
    bus.load_en   = 1'b0;
    bus.load_ten  = '0;
    bus.load_five = '0;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_short", 32'(bus.short), 0);
    chk("rst_eject10", 32'(bus.eject10), 0);
    chk("rst_eject5", 32'(bus.eject5), 0);
    chk("rst_rem_amt", 32'(bus.rem_amt), 0);
    chk("rst_cnt_ten", 32'(bus.cnt_ten), 0);
    chk("rst_cnt_five", 32'(bus.cnt_five), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1, 3, 3, 4, 0, 0);   // two tens, done in 16
    run_txn(1, 0, 5, 3, 0, 0);   // three fives, done in 23
    run_txn(1, 2, 0, 3, 0, 0);   // one ten, short by one five
    run_txn(1, 4, 4, 0, 0, 0);   // zero request
    run_txn(1, 0, 2, 2, 0, 0);   // fresh load with accept: no tens available
    run_txn(1, 5, 5, 5, 1, 0);   // load while busy is ignored
    run_txn(1, 6, 6, 3, 0, 1);   // request held through completion

    // Reset during an eject10 pulse
    wait_ready();
    @(negedge clk);
    bus.load_en = 1'b1; bus.load_ten = CNT_W'(5); bus.load_five = CNT_W'(5);
    bus.req_valid = 1'b1; bus.req_amt = AMT_W'(6);
    @(negedge clk);
    bus.load_en = 1'b0; bus.req_valid = 1'b0;
    k = 0;
    while (bus.eject10 !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_eject10_seen", 32'(bus.eject10), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_eject10", 32'(bus.eject10), 0);
    chk("mid_rst_cnt_ten", 32'(bus.cnt_ten), 0);
    chk("mid_rst_cnt_five", 32'(bus.cnt_five), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ten = 0; m_five = 0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.req_ready), 1);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    run_txn(0, 0, 0, 2, 0, 0);   // empty hoppers after reset: full shortfall

    for (int i = 0; i < 25; i++) begin
      run_txn(($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
              ($urandom_range(0, 4) == 0), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
